// File: rtl/fpu_elastic_pipe_pkg.sv
// Shared FPU datapath types: operand struct, pipe entry and occupancy-width helper.
package fpu_elastic_pipe_pkg;

  localparam int TAG_W_DEFAULT = 4;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float_point_num;

  typedef struct packed {
    float_point_num            data;
    logic [TAG_W_DEFAULT-1:0]  tag;
  } fp_pipe_entry_t;

  function automatic int occ_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fpu_elastic_pipe_if.sv
// Handshake, data and observation bundle of the elastic FPU pipe.
interface fpu_elastic_pipe_if #(
  parameter int STAGES = 6,
  parameter int TAG_W  = 4
);
  import fpu_elastic_pipe_pkg::*;

  localparam int OCC_W = occ_width(STAGES);

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  float_point_num       in_data;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  float_point_num       out_data;
  logic [TAG_W-1:0]     out_tag;
  logic [STAGES-1:0]    stage_valid;
  float_point_num       stage_data [0:STAGES-1];
  logic [OCC_W-1:0]     occupancy;

  modport master (
    output flush, in_valid, in_data, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, stage_valid, stage_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_data, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, stage_valid, stage_data, occupancy
  );

endinterface

// File: rtl/fpu_elastic_pipe_stage.sv
// One valid/ready register slot: accepts whenever empty or when downstream drains it.
module fpu_pipe_stage
  import fpu_elastic_pipe_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  float_point_num   up_data,
  input  logic [TAG_W-1:0] up_tag,
  output logic             down_valid,
  input  logic             down_ready,
  output float_point_num   down_data,
  output logic [TAG_W-1:0] down_tag
);

  logic             v;
  float_point_num   d;
  logic [TAG_W-1:0] t;
  logic             up_ready;

  assign up_ready = !v || down_ready;

  // Payload only moves with a valid entry; a bubble just clears v.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= 1'b0;
      d <= '0;
      t <= '0;
    end else if (flush) begin
      v <= 1'b0;
    end else if (up_ready) begin
      v <= up_valid;
      if (up_valid) begin
        d <= up_data;
        t <= up_tag;
      end
    end
  end

  assign down_valid = v;
  assign down_data  = d;
  assign down_tag   = t;

endmodule

// File: rtl/fpu_elastic_pipe.sv
// Elastic STAGES-deep valid/ready pipe with flush, per-stage taps and occupancy count.
module fpu_elastic_pipe
  import fpu_elastic_pipe_pkg::*;
#(
  parameter int STAGES = 6,
  parameter int TAG_W  = TAG_W_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  fpu_elastic_pipe_if.slave p
);

  localparam int OCC_W = occ_width(STAGES);

  logic [STAGES:0]    rdy;
  logic [STAGES-1:0]  v;
  logic [STAGES-1:0]  up_v;
  float_point_num     d    [STAGES];
  float_point_num     up_d [STAGES];
  logic [TAG_W-1:0]   t    [STAGES];
  logic [TAG_W-1:0]   up_t [STAGES];
  logic [OCC_W-1:0]   occ;
  logic               in_xfer;
  logic               out_xfer;

  // Ready of stage i unrolled from the chain: some slot at or after i is empty, or the consumer drains.
  assign rdy[STAGES] = p.out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign up_v[i] = p.in_valid;
      assign up_d[i] = p.in_data;
      assign up_t[i] = p.in_tag;
    end else begin : g_link
      assign up_v[i] = v[i-1];
      assign up_d[i] = d[i-1];
      assign up_t[i] = t[i-1];
    end

    assign rdy[i] = p.out_ready || !(&v[STAGES-1:i]);

    fpu_pipe_stage #(.TAG_W(TAG_W)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (p.flush),
      .up_valid   (up_v[i]),
      .up_data    (up_d[i]),
      .up_tag     (up_t[i]),
      .down_valid (v[i]),
      .down_ready (rdy[i+1]),
      .down_data  (d[i]),
      .down_tag   (t[i])
    );

    assign p.stage_data[i] = d[i];
  end

  assign p.in_ready    = rdy[0] && !p.flush;
  assign p.out_valid   = v[STAGES-1];
  assign p.out_data    = d[STAGES-1];
  assign p.out_tag     = t[STAGES-1];
  assign p.stage_valid = v;

  assign in_xfer  = p.in_valid && p.in_ready;
  assign out_xfer = v[STAGES-1] && p.out_ready;

  // Occupancy tracks accepted-minus-delivered, so it always equals popcount(v).
  always_ff @(posedge clk) begin
    if (rst || p.flush) begin
      occ <= '0;
    end else if (in_xfer && !out_xfer) begin
      occ <= occ + OCC_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occ <= occ - OCC_W'(1);
    end
  end

  assign p.occupancy = occ;

endmodule

// File: tb/tb_fpu_elastic_pipe.sv
// Bench for fpu_elastic_pipe: queue-based reference model for a 6-stage and a 1-stage instance.
module tb_fpu_elastic_pipe;
  import fpu_elastic_pipe_pkg::*;

  typedef struct {
    int          acc;
    logic [31:0] data;
    logic [3:0]  tag;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_elastic_pipe_if #(.STAGES(6), .TAG_W(4)) a ();
  fpu_elastic_pipe_if #(.STAGES(1), .TAG_W(2)) b ();

  fpu_elastic_pipe #(.STAGES(6), .TAG_W(4)) dut_a (.clk(clk), .rst(rst), .p(a));
  fpu_elastic_pipe #(.STAGES(1), .TAG_W(2)) dut_b (.clk(clk), .rst(rst), .p(b));

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  ent_t qa[$];
  ent_t qb[$];
  bit   en_a = 1'b0;
  bit   en_b = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Entries leave in acceptance order; the oldest one is never blocked, so it
  // reaches the output exactly S cycles after acceptance and waits there.
  // in_ready is high unless flushing, or every slot is full and the consumer stalls.
  task automatic mdl(input string nm, input int S, ref ent_t qq[$], ref bit en,
                     input logic fl, input logic iv, input logic ordy,
                     input logic [31:0] idata, input logic [3:0] itag,
                     input logic d_ir, input logic d_ov,
                     input logic [31:0] d_od, input logic [3:0] d_ot,
                     input int d_occ, input int d_pop);
    logic exp_ir;
    logic exp_ov;
    ent_t e;
    exp_ir = !fl && ((qq.size() < S) || ordy);
    exp_ov = 1'b0;
    if (qq.size() > 0) exp_ov = (cyc >= qq[0].acc + S);
    if (en) begin
      chk($sformatf("%s.in_ready", nm), d_ir, exp_ir);
      chk($sformatf("%s.out_valid", nm), d_ov, exp_ov);
      if (exp_ov) begin
        chk($sformatf("%s.out_data", nm), d_od, qq[0].data);
        chk($sformatf("%s.out_tag", nm), d_ot, qq[0].tag);
      end
      chk($sformatf("%s.occupancy", nm), d_occ, qq.size());
      chk($sformatf("%s.popcount", nm), d_pop, qq.size());
    end
    if (rst) begin
      qq.delete();
      en = 1'b1;
    end else if (en) begin
      if (exp_ov && ordy) void'(qq.pop_front());
      if (fl) begin
        qq.delete();
      end else if (iv && exp_ir) begin
        e.acc  = cyc;
        e.data = idata;
        e.tag  = itag;
        qq.push_back(e);
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    mdl("A", 6, qa, en_a, a.flush, a.in_valid, a.out_ready, a.in_data, a.in_tag,
        a.in_ready, a.out_valid, a.out_data, a.out_tag,
        int'(a.occupancy), $countones(a.stage_valid));
    mdl("B", 1, qb, en_b, b.flush, b.in_valid, b.out_ready, b.in_data, {2'b00, b.in_tag},
        b.in_ready, b.out_valid, b.out_data, {2'b00, b.out_tag},
        int'(b.occupancy), $countones(b.stage_valid));
    cyc++;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      sample();
      adv();
    end
  endtask

  initial begin
    int acc_cnt;
    int ov_cnt;
    a.flush = 1'b0; a.in_valid = 1'b0; a.in_data = '0; a.in_tag = '0; a.out_ready = 1'b0;
    b.flush = 1'b0; b.in_valid = 1'b0; b.in_data = '0; b.in_tag = '0; b.out_ready = 1'b0;

    rst = 1'b1;
    step(2);
    rst = 1'b0;
    sample();
    chk("A.reset out_valid", a.out_valid, 1'b0);
    chk("A.reset in_ready", a.in_ready, 1'b1);
    chk("A.reset occupancy", a.occupancy, 0);
    chk("A.reset stage_valid", a.stage_valid, 6'b000000);
    adv();

    // Stream 10 operands at full rate.
    a.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a.in_valid = 1'b1;
      a.in_data  = (i == 0) ? 32'h3F80_0000 : $urandom;
      a.in_tag   = 4'(i + 1);
      sample();
      if (i == 5) chk("A.latency not early", a.out_valid, 1'b0);
      if (i == 6) begin
        chk("A.first out_valid", a.out_valid, 1'b1);
        chk("A.first out_data", a.out_data, 32'h3F80_0000);
        chk("A.first out_tag", a.out_tag, 4'd1);
      end
      if (i >= 6) chk("A.steady occupancy", a.occupancy, 6);
      adv();
    end
    a.in_valid = 1'b0;
    step(12);

    // Fill against a stalled consumer, then release.
    a.out_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      a.in_valid = 1'b1;
      a.in_data  = $urandom;
      a.in_tag   = 4'($urandom);
      sample();
      if (a.in_ready) acc_cnt++;
      adv();
    end
    a.in_valid = 1'b0;
    sample();
    chk("A.stall accepted", acc_cnt, 6);
    chk("A.stall in_ready", a.in_ready, 1'b0);
    chk("A.stall occupancy", a.occupancy, 6);
    chk("A.stall stage_valid", a.stage_valid, 6'b111111);
    adv();
    a.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("A.drain out_valid", a.out_valid, 1'b1);
      adv();
    end
    sample();
    chk("A.drained out_valid", a.out_valid, 1'b0);
    adv();

    // Bubble collapse under back-pressure.
    a.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a.in_valid = (i % 2 == 0);
      a.in_data  = $urandom;
      a.in_tag   = 4'($urandom);
      step(1);
    end
    a.in_valid = 1'b0;
    step(6);
    sample();
    chk("A.bubble stage_valid", a.stage_valid, 6'b110000);
    chk("A.bubble occupancy", a.occupancy, 2);
    adv();
    a.out_ready = 1'b1;
    step(4);

    // Flush with four entries held and an operand offered.
    a.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a.in_valid = 1'b1;
      a.in_data  = $urandom;
      a.in_tag   = 4'($urandom);
      step(1);
    end
    a.flush    = 1'b1;
    a.in_data  = 32'hDEAD_BEEF;
    a.in_tag   = 4'hF;
    sample();
    chk("A.flush in_ready", a.in_ready, 1'b0);
    chk("A.preflush occupancy", a.occupancy, 4);
    adv();
    a.flush    = 1'b0;
    a.in_valid = 1'b0;
    sample();
    chk("A.postflush occupancy", a.occupancy, 0);
    chk("A.postflush out_valid", a.out_valid, 1'b0);
    chk("A.postflush stage_valid", a.stage_valid, 6'b000000);
    adv();
    a.out_ready = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      sample();
      if (a.out_valid) ov_cnt++;
      adv();
    end
    chk("A.postflush outputs", ov_cnt, 0);

    // Reset with three entries in flight.
    for (int i = 0; i < 3; i++) begin
      a.in_valid = 1'b1;
      a.in_data  = $urandom;
      a.in_tag   = 4'($urandom);
      step(1);
    end
    a.in_valid = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    sample();
    chk("A.midreset out_valid", a.out_valid, 1'b0);
    chk("A.midreset occupancy", a.occupancy, 0);
    chk("A.midreset in_ready", a.in_ready, 1'b1);
    adv();
    ov_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      sample();
      if (a.out_valid) ov_cnt++;
      adv();
    end
    chk("A.postreset outputs", ov_cnt, 0);

    // Random traffic on the 6-stage pipe with occasional flush.
    for (int i = 0; i < 300; i++) begin
      a.in_valid  = $urandom_range(0, 1) == 1;
      a.out_ready = $urandom_range(0, 3) != 0;
      a.flush     = $urandom_range(0, 31) == 0;
      a.in_data   = $urandom;
      a.in_tag    = 4'($urandom);
      step(1);
    end
    a.flush = 1'b0; a.in_valid = 1'b0; a.out_ready = 1'b1;
    step(8);

    // Random traffic on the single-stage pipe.
    for (int i = 0; i < 1000; i++) begin
      b.in_valid  = $urandom_range(0, 1) == 1;
      b.out_ready = $urandom_range(0, 1) == 1;
      b.in_data   = $urandom;
      b.in_tag    = 2'($urandom);
      sample();
      chk("B.occupancy bound", b.occupancy <= 1, 1'b1);
      adv();
    end
    b.in_valid = 1'b0; b.out_ready = 1'b1;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
